// File: rtl/fir_decimator.sv
// Block-average decimator: sums DECIM consecutive accepted samples, emits the
// floor average through a one-deep output register with a sticky drop flag.
module fir_decimator #(
  parameter int DATA_W = 16,
  parameter int DECIM  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] filtered_signal,
  input  logic                     in_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int SH    = $clog2(DECIM);
  localparam int ACC_W = DATA_W + SH;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [ACC_W-1:0]   r_acc;
  logic        [SH-1:0]      r_phase;
  logic signed [DATA_W-1:0]  r_data;
  logic                      r_overflow;

  logic signed [ACC_W-1:0]   w_sample_ext;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [ACC_W-1:0]   w_shifted;
  logic signed [DATA_W-1:0]  w_result;
  logic                      w_last;
  logic                      w_take;
  logic                      w_load;
  logic                      w_drop;

  assign w_sample_ext = {{SH{filtered_signal[DATA_W-1]}}, filtered_signal};
  assign w_sum        = r_acc + w_sample_ext;
  // Average of DECIM DATA_W-bit values always fits DATA_W bits, so truncation is exact.
  assign w_shifted    = w_sum >>> SH;
  assign w_result     = w_shifted[DATA_W-1:0];
  assign w_last       = in_valid && (r_phase == SH'(DECIM - 1));
  assign w_take       = (r_state == FULL) && out_ready;
  assign w_load       = w_last && ((r_state == EMPTY) || out_ready);
  assign w_drop       = w_last && (r_state == FULL) && !out_ready;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (in_valid) begin
      if (w_last) begin
        r_acc   <= '0;
        r_phase <= '0;
      end else begin
        r_acc   <= w_sum;
        r_phase <= r_phase + SH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_last) w_state_nxt = FULL;
      FULL:    if (w_take && !w_last) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (r_state == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_load) begin
        r_data <= w_result;
      end
      // A drop on the same edge as a clear leaves the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_data = r_data;
  assign overflow = r_overflow;

endmodule
